// File: rtl/game_display_scan.sv
// Room display: latches a one-hot room code and scans "r<room>" or "Err" onto an N-digit common-anode 7-seg display.
// Latency: load -> registered state -> LED_out/Anode_Activate next cycle; no backpressure (load is a fire-and-forget strobe).
// Optional blink on room change is enabled with GAME_DISPLAY_BLINK_EN.
module game_display_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int NUM_ROOMS   = 9,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_HALF  = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_ROOMS-1:0]  digit_data,
    input  logic                  load,
    output logic [NUM_DIGITS-1:0] Anode_Activate,
    output logic [6:0]            LED_out,
    output logic                  room_changed,
    output logic                  code_err
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = $clog2(NUM_DIGITS);
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SEL_MAX = SW'(NUM_DIGITS - 1);
    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_R     = 7'b1111010;
    localparam logic [6:0] G_E     = 7'b0110000;

    if (NUM_DIGITS < 3 || NUM_DIGITS > 8 || NUM_ROOMS < 1 || NUM_ROOMS > 99 ||
        REFRESH_DIV < 1 || BLINK_HALF < 1) begin : g_param_check
        $error("game_display_scan: parameter out of range");
    end

    logic [RW-1:0] refresh_q, refresh_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [6:0]    room_q, room_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          changed_q, changed_d;

    logic [6:0] hot_idx;
    logic       one_hot;
    logic       accept;
    logic [6:0] tens, ones;
    logic [NUM_DIGITS-1:0] scan_an;

    always_comb begin
        hot_idx = '0;
        for (int i = 0; i < NUM_ROOMS; i++) begin
            if (digit_data[i]) hot_idx = 7'(i + 1);
        end
    end

    assign one_hot = ($countones(digit_data) == 1);
    assign accept  = load && one_hot;

    always_comb begin
        room_d    = accept ? hot_idx : room_q;
        valid_d   = valid_q | accept;
        err_d     = load ? !one_hot : err_q;
        changed_d = accept && (!valid_q || (hot_idx != room_q));
        // Scan free-runs; loads never touch it.
        refresh_d = (refresh_q == REF_MAX) ? '0 : refresh_q + 1'b1;
        sel_d     = sel_q;
        if (refresh_q == REF_MAX) sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
            sel_q     <= '0;
            room_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            refresh_q <= refresh_d;
            sel_q     <= sel_d;
            room_q    <= room_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            changed_q <= changed_d;
        end
    end

    function automatic logic [6:0] glyph(input logic [6:0] v);
        case (v)
            7'd0:    glyph = 7'b0000001;
            7'd1:    glyph = 7'b1001111;
            7'd2:    glyph = 7'b0010010;
            7'd3:    glyph = 7'b0000110;
            7'd4:    glyph = 7'b1001100;
            7'd5:    glyph = 7'b0100100;
            7'd6:    glyph = 7'b0100000;
            7'd7:    glyph = 7'b0001111;
            7'd8:    glyph = 7'b0000000;
            7'd9:    glyph = 7'b0000100;
            default: glyph = G_BLANK;
        endcase
    endfunction

    assign tens = room_q / 7'd10;
    assign ones = room_q % 7'd10;

    always_comb begin
        LED_out = G_BLANK;
        if (err_q) begin
            if (sel_q == SEL_MAX) LED_out = G_E;
            else if (sel_q == SW'(NUM_DIGITS - 2) || sel_q == SW'(NUM_DIGITS - 3)) LED_out = G_R;
        end else if (valid_q) begin
            if (sel_q == SEL_MAX) LED_out = G_R;
            else if (sel_q == SW'(1)) LED_out = (tens == 7'd0) ? G_BLANK : glyph(tens);
            else if (sel_q == SW'(0)) LED_out = glyph(ones);
        end
    end

    assign scan_an = ~(NUM_DIGITS'(1) << sel_q);

`ifdef GAME_DISPLAY_BLINK_EN
    localparam int BLINK_TOP = 6 * BLINK_HALF;
    localparam int BW = $clog2(BLINK_TOP + 1);
    logic [BW-1:0] blink_q, blink_d, blink_m1, blink_ph;
    logic          blink_off;

    always_comb begin
        blink_d = blink_q;
        if (changed_d) blink_d = BW'(BLINK_TOP);
        else if (blink_q != '0) blink_d = blink_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blink_q <= '0;
        else        blink_q <= blink_d;
    end

    // Odd half-periods (counting down from the end of the blink) blank the whole display.
    assign blink_m1  = blink_q - 1'b1;
    assign blink_ph  = blink_m1 / BW'(BLINK_HALF);
    assign blink_off = (blink_q != '0) && blink_ph[0];
    assign Anode_Activate = blink_off ? '1 : scan_an;
`else
    assign Anode_Activate = scan_an;
`endif

    assign room_changed = changed_q;
    assign code_err     = err_q;
endmodule

// File: tb/tb_game_display_scan.sv
// Bench for game_display_scan: table of load vectors, reset corner cases, then random loads vs a text-level display model.
module tb_game_display_scan;
    localparam int ND = 4;
    localparam int NR = 9;
    localparam int RD = 4;
    localparam int BH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [NR-1:0] digit_data;
    logic [ND-1:0] Anode_Activate;
    logic [6:0]    LED_out;
    logic          room_changed;
    logic          code_err;

    game_display_scan #(
        .NUM_DIGITS(ND), .NUM_ROOMS(NR), .REFRESH_DIV(RD), .BLINK_HALF(BH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digit_data(digit_data), .load(load),
        .Anode_Activate(Anode_Activate), .LED_out(LED_out),
        .room_changed(room_changed), .code_err(code_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: cycle count since reset, latched room, and what text the display should read.
    int m_ticks, m_room, m_blink;
    bit m_valid, m_err, m_pulse;

    typedef struct {
        logic [NR-1:0] dat;
        bit            pulse;
        bit            err;
        logic [6:0]    d0;
        logic [6:0]    d3;
    } vec_t;
    vec_t tbl[10];

    function automatic logic [6:0] glyph_of(input byte c);
        case (c)
            "0": return 7'b0000001;
            "1": return 7'b1001111;
            "2": return 7'b0010010;
            "3": return 7'b0000110;
            "4": return 7'b1001100;
            "5": return 7'b0100100;
            "6": return 7'b0100000;
            "7": return 7'b0001111;
            "8": return 7'b0000000;
            "9": return 7'b0000100;
            "r": return 7'b1111010;
            "E": return 7'b0110000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic string disp_text();
        if (m_err) return "Err ";
        if (m_valid) return $sformatf("r%3d", m_room);
        return "    ";
    endfunction

    function automatic int m_sel();
        return (m_ticks / RD) % ND;
    endfunction

    function automatic logic [ND-1:0] m_anode();
        logic [ND-1:0] a;
        a = '1;
        a[m_sel()] = 1'b0;
`ifdef GAME_DISPLAY_BLINK_EN
        if (m_blink != 0 && (((m_blink - 1) / BH) % 2) == 1) a = '1;
`endif
        return a;
    endfunction

    task automatic model_reset();
        m_ticks = 0; m_room = 0; m_blink = 0;
        m_valid = 0; m_err = 0; m_pulse = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        string s;
        s = disp_text();
        chk("anode", 32'(Anode_Activate), 32'(m_anode()));
        chk("led", 32'(LED_out), 32'(glyph_of(s[ND - 1 - m_sel()])));
        chk("room_changed", 32'(room_changed), 32'(m_pulse));
        chk("code_err", 32'(code_err), 32'(m_err));
    endtask

    task automatic step(input logic ld, input logic [NR-1:0] d);
        int idx;
        load = ld;
        digit_data = d;
        @(posedge clk);
        m_ticks++;
        m_pulse = 0;
        if (ld) begin
            if ($countones(d) == 1) begin
                idx = 0;
                for (int i = 0; i < NR; i++) if (d[i]) idx = i + 1;
                m_pulse = !m_valid || (idx != m_room);
                m_room  = idx;
                m_valid = 1;
                m_err   = 0;
            end else begin
                m_err = 1;
            end
        end
        if (m_pulse) m_blink = 6 * BH;
        else if (m_blink > 0) m_blink--;
        #1;
        load = 1'b0;
        check_all();
    endtask

    task automatic run_to_sel(input int s);
        for (int k = 0; k < 20; k++) begin
            if (m_sel() == s) return;
            step(1'b0, '0);
        end
        chk("run_to_sel_timeout", 32'(m_sel()), 32'(s));
    endtask

    initial begin
        tbl[0] = '{9'b000000001, 1, 0, 7'b1001111, 7'b1111010};
        tbl[1] = '{9'b000000010, 1, 0, 7'b0010010, 7'b1111010};
        tbl[2] = '{9'b000000100, 1, 0, 7'b0000110, 7'b1111010};
        tbl[3] = '{9'b000001000, 1, 0, 7'b1001100, 7'b1111010};
        tbl[4] = '{9'b000000100, 1, 0, 7'b0000110, 7'b1111010};
        tbl[5] = '{9'b000010000, 1, 0, 7'b0100100, 7'b1111010};
        tbl[6] = '{9'b000010000, 0, 0, 7'b0100100, 7'b1111010};
        tbl[7] = '{9'b000000000, 0, 1, 7'b1111111, 7'b0110000};
        tbl[8] = '{9'b000000110, 0, 1, 7'b1111111, 7'b0110000};
        tbl[9] = '{9'b100000000, 1, 0, 7'b0000100, 7'b1111010};

        rst_n = 1'b0;
        load = 1'b0;
        digit_data = '0;
        model_reset();
        #12;
        chk("rst_anode", 32'(Anode_Activate), 32'h0000_000E);
        chk("rst_led", 32'(LED_out), 32'h0000_007F);
        chk("rst_room_changed", 32'(room_changed), 32'h0);
        chk("rst_code_err", 32'(code_err), 32'h0);
        rst_n = 1'b1;

        // Idle scan after reset: digit moves every RD clocks.
        repeat (4) step(1'b0, '0);
        chk("scan_step1", 32'(Anode_Activate), 32'h0000_000D);
        repeat (16) step(1'b0, '0);

        for (int v = 0; v < 10; v++) begin
            step(1'b1, tbl[v].dat);
            chk($sformatf("tbl%0d_pulse", v), 32'(room_changed), 32'(tbl[v].pulse));
            chk($sformatf("tbl%0d_err", v), 32'(code_err), 32'(tbl[v].err));
            step(1'b0, '0);
            chk($sformatf("tbl%0d_pulse_end", v), 32'(room_changed), 32'h0);
            run_to_sel(0);
            chk($sformatf("tbl%0d_d0", v), 32'(LED_out), 32'(tbl[v].d0));
            run_to_sel(3);
            chk($sformatf("tbl%0d_d3", v), 32'(LED_out), 32'(tbl[v].d3));
        end

        // Asynchronous reset in the middle of digit 2, checked before any clock edge.
        run_to_sel(2);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_anode", 32'(Anode_Activate), 32'h0000_000E);
        chk("async_rst_led", 32'(LED_out), 32'h0000_007F);
        chk("async_rst_err", 32'(code_err), 32'h0);
        model_reset();
        #1 rst_n = 1'b1;
        repeat (8) step(1'b0, '0);

        repeat (500) begin
            logic ld;
            logic [NR-1:0] d;
            ld = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) d = NR'(1) << $urandom_range(0, NR - 1);
            else d = NR'($urandom);
            step(ld, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
